// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU/loader memory port arbiter.
// The FSM state encoding and owner codes are used by both the top and the select logic.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_MEM_LAT    = 1;
  localparam int unsigned DEF_STARVE_MAX = 4;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_priority_select.sv
// Picks the next memory owner: CPU has priority unless the loader has waited
// through STARVE_MAX consecutive CPU grants.
module arb_priority_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic CLK,
  input  logic Reset,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_owner
);

  localparam int unsigned CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_reg;
  logic [CW-1:0] starve_cnt_next;

  assign grant_valid = cpu_req | ldr_req;
  assign grant_owner = (ldr_req && (!cpu_req || starve_cnt_reg == STARVE_LIMIT))
                       ? OWNER_LDR : OWNER_CPU;

  // The count only tracks an outstanding loader request; it saturates at the limit.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!ldr_req) begin
      starve_cnt_next = '0;
    end else if (grant_en && grant_valid) begin
      if (grant_owner == OWNER_LDR) begin
        starve_cnt_next = '0;
      end else if (starve_cnt_reg != STARVE_LIMIT) begin
        starve_cnt_next = starve_cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU and a loader/debug port, one access at a
// time: IDLE -> ISSUE -> [WAIT] -> DONE, stalling the CPU while its access is pending.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam int unsigned LW = cnt_width(MEM_LAT - 1);

  arb_state_t        state_reg;
  arb_state_t        state_next;
  logic [LW-1:0]     lat_cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              owner_reg;
  logic              grant_valid;
  logic              grant_owner;
  logic              grant_en;

  assign grant_en = (state_reg == ST_IDLE);

  arb_priority_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .CLK         (CLK),
    .Reset       (Reset),
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
    .grant_en    (grant_en),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (grant_valid) state_next = ST_ISSUE;
      ST_ISSUE: state_next = (we_reg || MEM_LAT == 1) ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (lat_cnt_reg <= LW'(1)) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request latch and latency counter; the latch also drives the memory address/data.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      owner_reg   <= OWNER_CPU;
      lat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_reg <= grant_owner;
            we_reg    <= (grant_owner == OWNER_LDR) ? ldr_we    : cpu_we;
            addr_reg  <= (grant_owner == OWNER_LDR) ? ldr_addr  : cpu_addr;
            wdata_reg <= (grant_owner == OWNER_LDR) ? ldr_wdata : cpu_wdata;
          end
        end
        ST_ISSUE: lat_cnt_reg <= LW'(MEM_LAT - 1);
        ST_WAIT:  lat_cnt_reg <= lat_cnt_reg - LW'(1);
        default:  ;
      endcase
    end
  end

  // One read-data register per requester, indexed by owner code (0=CPU, 1=loader).
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    logic [DATA_W-1:0] rdata_reg;
    always_ff @(posedge CLK) begin
      if (Reset) begin
        rdata_reg <= '0;
      end else if (state_reg == ST_DONE && !we_reg && owner_reg == 1'(gi)) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign cpu_rdata = g_rdata[0].rdata_reg;
  assign ldr_rdata = g_rdata[1].rdata_reg;

  // mem_en follows the ISSUE state even while Reset is high, so a write issued
  // in the reset cycle still reaches the memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_done  = 1'b0;
    ldr_done  = 1'b0;
    mem_addr  = addr_reg;
    mem_wdata = wdata_reg;
    owner     = owner_reg;
    if (state_reg == ST_ISSUE) begin
      mem_en = 1'b1;
      mem_we = we_reg;
    end
    if (state_reg == ST_DONE) begin
      cpu_done = (owner_reg == OWNER_CPU);
      ldr_done = (owner_reg == OWNER_LDR);
    end
    cpu_stall = cpu_req & ~cpu_done;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a uses MEM_LAT=1/STARVE_MAX=4, dut_b uses MEM_LAT=3/STARVE_MAX=2,
// each with its own small behavioural memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic Reset = 1'b1;
  int checks = 0;
  int failures = 0;

  logic        cpu_req_a = 0, cpu_we_a = 0, ldr_req_a = 0, ldr_we_a = 0;
  logic [15:0] cpu_addr_a = 0, cpu_wdata_a = 0, ldr_addr_a = 0, ldr_wdata_a = 0;
  logic [15:0] cpu_rdata_a, ldr_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        cpu_done_a, cpu_stall_a, ldr_done_a, mem_en_a, mem_we_a, owner_a;

  logic        cpu_req_b = 0, cpu_we_b = 0, ldr_req_b = 0, ldr_we_b = 0;
  logic [15:0] cpu_addr_b = 0, cpu_wdata_b = 0, ldr_addr_b = 0, ldr_wdata_b = 0;
  logic [15:0] cpu_rdata_b, ldr_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        cpu_done_b, cpu_stall_b, ldr_done_b, mem_en_b, mem_we_b, owner_b;

  mem_port_arbiter dut_a (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
    .cpu_rdata(cpu_rdata_a), .cpu_done(cpu_done_a), .cpu_stall(cpu_stall_a),
    .ldr_req(ldr_req_a), .ldr_we(ldr_we_a), .ldr_addr(ldr_addr_a), .ldr_wdata(ldr_wdata_a),
    .ldr_rdata(ldr_rdata_a), .ldr_done(ldr_done_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .owner(owner_a)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(2)) dut_b (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_rdata(cpu_rdata_b), .cpu_done(cpu_done_b), .cpu_stall(cpu_stall_b),
    .ldr_req(ldr_req_b), .ldr_we(ldr_we_b), .ldr_addr(ldr_addr_b), .ldr_wdata(ldr_wdata_b),
    .ldr_rdata(ldr_rdata_b), .ldr_done(ldr_done_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .owner(owner_b)
  );

  // Memory models: registered read, extra pipeline stages for dut_b.
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] pipe_b [3];
  logic        pre_en_a = 0, pre_en_b = 0;
  logic [7:0]  pre_addr = 0;
  logic [15:0] pre_data = 0;

  always @(posedge CLK) begin
    if (pre_en_a) mem_a[pre_addr] <= pre_data;
    else if (mem_en_a && mem_we_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
    if (mem_en_a) mem_rdata_a <= mem_a[mem_addr_a[7:0]];
  end

  always @(posedge CLK) begin
    if (pre_en_b) mem_b[pre_addr] <= pre_data;
    else if (mem_en_b && mem_we_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
    if (mem_en_b) pipe_b[0] <= mem_b[mem_addr_b[7:0]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_rdata_b = pipe_b[2];

  always @(negedge CLK) begin
    if (cpu_done_a || ldr_done_a)
      $display("txn dut_a owner=%0d we=%0d addr=%h wdata=%h", owner_a, dut_a.we_reg, mem_addr_a, mem_wdata_a);
    if (cpu_done_b || ldr_done_b)
      $display("txn dut_b owner=%0d we=%0d addr=%h wdata=%h", owner_b, dut_b.we_reg, mem_addr_b, mem_wdata_b);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic preload(input bit to_b, input logic [7:0] a, input logic [15:0] d);
    step();
    pre_addr = a;
    pre_data = d;
    if (to_b) pre_en_b = 1'b1; else pre_en_a = 1'b1;
    step();
    pre_en_a = 1'b0;
    pre_en_b = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    preload(1'b0, 8'h10, 16'hBEEF);
    for (int i = 0; i < 3; i++) preload(1'b1, 8'(8'h30 + i), 16'(16'hC030 + i));
    preload(1'b1, 8'h40, 16'hC040);
    preload(1'b1, 8'h50, 16'hC050);
    settle();
    checks++; if (mem_en_a !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en_a); end
    checks++; if (mem_we_a !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we_a); end
    checks++; if (cpu_done_a !== 1'b0 || ldr_done_a !== 1'b0) begin failures++; $display("FAIL rst_done got=%b%b exp=00", cpu_done_a, ldr_done_a); end
    checks++; if (owner_a !== 1'b0) begin failures++; $display("FAIL rst_owner got=%b exp=0", owner_a); end
    checks++; if (mem_addr_a !== 16'h0 || mem_wdata_a !== 16'h0) begin failures++; $display("FAIL rst_mem_addr_wdata got=%h/%h exp=0000/0000", mem_addr_a, mem_wdata_a); end
    checks++; if (cpu_rdata_a !== 16'h0 || ldr_rdata_a !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0000/0000", cpu_rdata_a, ldr_rdata_a); end
    checks++; if (mem_en_b !== 1'b0 || owner_b !== 1'b0) begin failures++; $display("FAIL rst_b got=%b/%b exp=0/0", mem_en_b, owner_b); end
    step();
    Reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    step();
    cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 16'h0010;
    settle();
    checks++; if (cpu_stall_a !== 1'b1 || mem_en_a !== 1'b0) begin failures++; $display("FAIL rd_c0 stall/en got=%b/%b exp=1/0", cpu_stall_a, mem_en_a); end
    step(); settle();
    checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== 16'h0010) begin failures++; $display("FAIL rd_c1_issue got en=%b we=%b addr=%h exp 1/0/0010", mem_en_a, mem_we_a, mem_addr_a); end
    checks++; if (cpu_stall_a !== 1'b1 || cpu_done_a !== 1'b0) begin failures++; $display("FAIL rd_c1 stall/done got=%b/%b exp=1/0", cpu_stall_a, cpu_done_a); end
    step(); settle();
    checks++; if (cpu_done_a !== 1'b1 || cpu_stall_a !== 1'b0 || mem_en_a !== 1'b0) begin failures++; $display("FAIL rd_c2 done/stall/en got=%b/%b/%b exp=1/0/0", cpu_done_a, cpu_stall_a, mem_en_a); end
    step();
    cpu_req_a = 1'b0;
    settle();
    checks++; if (cpu_rdata_a !== 16'hBEEF || cpu_done_a !== 1'b0) begin failures++; $display("FAIL rd_c3 rdata/done got=%h/%b exp=beef/0", cpu_rdata_a, cpu_done_a); end
  endtask

  task automatic test_ldr_write_cpu_read();
    step();
    ldr_req_a = 1'b1; ldr_we_a = 1'b1; ldr_addr_a = 16'h0002; ldr_wdata_a = 16'h1234;
    step(); settle();
    checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b1 || mem_wdata_a !== 16'h1234 || owner_a !== 1'b1) begin failures++; $display("FAIL wr_c1 en/we/wdata/owner got=%b/%b/%h/%b exp=1/1/1234/1", mem_en_a, mem_we_a, mem_wdata_a, owner_a); end
    step(); settle();
    checks++; if (ldr_done_a !== 1'b1 || cpu_done_a !== 1'b0) begin failures++; $display("FAIL wr_c2 ldr_done/cpu_done got=%b/%b exp=1/0", ldr_done_a, cpu_done_a); end
    step();
    ldr_req_a = 1'b0;
    cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 16'h0002;
    settle();
    checks++; if (mem_a[2] !== 16'h1234 || owner_a !== 1'b1) begin failures++; $display("FAIL wr_commit mem/owner got=%h/%b exp=1234/1", mem_a[2], owner_a); end
    step(); settle();
    checks++; if (owner_a !== 1'b0 || mem_en_a !== 1'b1) begin failures++; $display("FAIL wr_cpu_issue owner/en got=%b/%b exp=0/1", owner_a, mem_en_a); end
    step(); settle();
    checks++; if (cpu_done_a !== 1'b1) begin failures++; $display("FAIL wr_cpu_done got=%b exp=1", cpu_done_a); end
    step();
    cpu_req_a = 1'b0;
    settle();
    checks++; if (cpu_rdata_a !== 16'h1234 || ldr_rdata_a !== 16'h0000) begin failures++; $display("FAIL wr_readback cpu/ldr rdata got=%h/%h exp=1234/0000", cpu_rdata_a, ldr_rdata_a); end
  endtask

  task automatic test_contention();
    step();
    cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 16'h0010;
    ldr_req_a = 1'b1; ldr_we_a = 1'b0; ldr_addr_a = 16'h0002;
    step(); settle();
    checks++; if (mem_en_a !== 1'b1 || owner_a !== 1'b0 || mem_addr_a !== 16'h0010) begin failures++; $display("FAIL ct_c1 en/owner/addr got=%b/%b/%h exp=1/0/0010", mem_en_a, owner_a, mem_addr_a); end
    step(); settle();
    checks++; if (cpu_done_a !== 1'b1 || ldr_done_a !== 1'b0) begin failures++; $display("FAIL ct_c2 cpu/ldr done got=%b/%b exp=1/0", cpu_done_a, ldr_done_a); end
    step();
    cpu_req_a = 1'b0;
    settle();
    checks++; if (mem_en_a !== 1'b0) begin failures++; $display("FAIL ct_c3 en got=%b exp=0", mem_en_a); end
    step(); settle();
    checks++; if (mem_en_a !== 1'b1 || owner_a !== 1'b1 || mem_addr_a !== 16'h0002) begin failures++; $display("FAIL ct_c4 en/owner/addr got=%b/%b/%h exp=1/1/0002", mem_en_a, owner_a, mem_addr_a); end
    step(); settle();
    checks++; if (ldr_done_a !== 1'b1 || cpu_done_a !== 1'b0 || ldr_rdata_a !== 16'h0000) begin failures++; $display("FAIL ct_c5 ldr_done/cpu_done/ldr_rdata got=%b/%b/%h exp=1/0/0000", ldr_done_a, cpu_done_a, ldr_rdata_a); end
    step();
    ldr_req_a = 1'b0;
    settle();
    checks++; if (ldr_rdata_a !== 16'h1234 || cpu_rdata_a !== 16'hBEEF) begin failures++; $display("FAIL ct_c6 ldr/cpu rdata got=%h/%h exp=1234/beef", ldr_rdata_a, cpu_rdata_a); end
  endtask

  task automatic test_reset_in_issue_write();
    bit done_seen;
    step();
    cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_addr_a = 16'h0020; cpu_wdata_a = 16'hA5A5;
    step();
    Reset = 1'b1;
    settle();
    checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b1 || mem_addr_a !== 16'h0020) begin failures++; $display("FAIL rw_issue en/we/addr got=%b/%b/%h exp=1/1/0020", mem_en_a, mem_we_a, mem_addr_a); end
    step();
    Reset = 1'b0;
    cpu_req_a = 1'b0;
    settle();
    checks++; if (mem_a[8'h20] !== 16'hA5A5) begin failures++; $display("FAIL rw_commit mem got=%h exp=a5a5", mem_a[8'h20]); end
    checks++; if (mem_addr_a !== 16'h0 || mem_en_a !== 1'b0 || cpu_rdata_a !== 16'h0) begin failures++; $display("FAIL rw_cleared addr/en/rdata got=%h/%b/%h exp=0000/0/0000", mem_addr_a, mem_en_a, cpu_rdata_a); end
    done_seen = cpu_done_a;
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      if (cpu_done_a === 1'b1) done_seen = 1'b1;
    end
    checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL rw_no_done got=%b exp=0", done_seen); end
  endtask

  task automatic test_starvation();
    logic exp_own [4];
    int   exp_cnt [4];
    logic got_own [4];
    int   got_cnt [4];
    int   grants = 0;
    int   cycles = 0;
    bit   cpu_fin, ldr_fin;
    exp_own = '{OWNER_CPU, OWNER_CPU, OWNER_LDR, OWNER_CPU};
    exp_cnt = '{1, 2, 0, 0};
    step();
    cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_addr_b = 16'h0030;
    ldr_req_b = 1'b1; ldr_we_b = 1'b0; ldr_addr_b = 16'h0040;
    while ((cpu_req_b || ldr_req_b) && cycles < 80) begin
      settle();
      if (mem_en_b && grants < 4) begin
        got_own[grants] = owner_b;
        got_cnt[grants] = int'(dut_b.u_select.starve_cnt_reg);
        grants++;
      end
      cpu_fin = cpu_done_b;
      ldr_fin = ldr_done_b;
      step();
      cycles++;
      if (cpu_fin) begin
        checks++; if (cpu_rdata_b !== (16'hC000 | cpu_addr_b)) begin failures++; $display("FAIL sv_cpu_rdata addr=%h got=%h exp=%h", cpu_addr_b, cpu_rdata_b, 16'hC000 | cpu_addr_b); end
        if (grants >= 4) cpu_req_b = 1'b0;
        else cpu_addr_b = cpu_addr_b + 16'h1;
      end
      if (ldr_fin) begin
        checks++; if (ldr_rdata_b !== 16'hC040) begin failures++; $display("FAIL sv_ldr_rdata got=%h exp=c040", ldr_rdata_b); end
        ldr_req_b = 1'b0;
      end
    end
    checks++; if (cycles >= 80 || grants != 4) begin failures++; $display("FAIL sv_timeout grants got=%0d exp=4 cycles=%0d", grants, cycles); end
    cpu_req_b = 1'b0;
    ldr_req_b = 1'b0;
    for (int i = 0; i < grants; i++) begin
      checks++; if (got_own[i] !== exp_own[i] || got_cnt[i] != exp_cnt[i]) begin failures++; $display("FAIL sv_grant%0d owner/cnt got=%b/%0d exp=%b/%0d", i, got_own[i], got_cnt[i], exp_own[i], exp_cnt[i]); end
    end
  endtask

  task automatic test_reset_in_wait();
    bit done_seen;
    step();
    cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_addr_b = 16'h0050;
    settle();
    checks++; if (cpu_stall_b !== 1'b1) begin failures++; $display("FAIL rwt_stall got=%b exp=1", cpu_stall_b); end
    step(); settle();
    checks++; if (mem_en_b !== 1'b1) begin failures++; $display("FAIL rwt_issue en got=%b exp=1", mem_en_b); end
    step();
    Reset = 1'b1;
    settle();
    checks++; if (dut_b.state_reg !== ST_WAIT || mem_en_b !== 1'b0) begin failures++; $display("FAIL rwt_wait state/en got=%0d/%b exp=%0d/0", dut_b.state_reg, mem_en_b, ST_WAIT); end
    step();
    Reset = 1'b0;
    cpu_req_b = 1'b0;
    settle();
    checks++; if (dut_b.state_reg !== ST_IDLE || mem_en_b !== 1'b0 || cpu_rdata_b !== 16'h0) begin failures++; $display("FAIL rwt_after state/en/rdata got=%0d/%b/%h exp=%0d/0/0000", dut_b.state_reg, mem_en_b, cpu_rdata_b, ST_IDLE); end
    done_seen = cpu_done_b;
    for (int i = 0; i < 5; i++) begin
      step(); settle();
      if (cpu_done_b === 1'b1) done_seen = 1'b1;
    end
    checks++; if (done_seen !== 1'b0 || cpu_rdata_b !== 16'h0) begin failures++; $display("FAIL rwt_no_done done/rdata got=%b/%h exp=0/0000", done_seen, cpu_rdata_b); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write_cpu_read();
    test_contention();
    test_reset_in_issue_write();
    test_starvation();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
